// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   uart_state_t   : 3-bit receive FSM state encoding
//   Default*       : default clock / baud / oversampling constants
//   calc_div()     : clocks per oversampling tick, integer-truncated, never below 1
//   cnt_width()    : counter width able to hold 0..n-1, never below 1
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } uart_state_t;

  localparam int unsigned DefaultClkHz = 100_000_000;
  localparam int unsigned DefaultBaud  = 9600;
  localparam int unsigned DefaultOsr   = 16;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned osr);
    int unsigned d;
    d = clk_hz / (baud * osr);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator.
//   clk   : system clock
//   reset : synchronous, active-high; clears the counter
//   tick  : high for one clk every DIV clocks
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = cnt_width(DIV);
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == Last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == Last);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start-bit qualification.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   rxd       : asynchronous serial line, idle high
//   rx_data   : last correctly received byte
//   rx_valid  : level, rx_data holds an unconsumed byte
//   rx_ack    : one-cycle pulse, consumer has taken rx_data
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while rx_valid was still high
//   busy      : FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefaultClkHz,
  parameter int unsigned BAUD   = DefaultBaud,
  parameter int unsigned OSR    = DefaultOsr
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned Div = calc_div(CLK_HZ, BAUD, OSR);
  localparam int unsigned OsW = cnt_width(OSR);
  // Start bit is re-checked half a bit in; data/stop bits every full bit.
  localparam logic [OsW-1:0] HalfLast = OsW'(OSR / 2 - 1);
  localparam logic [OsW-1:0] BitLast  = OsW'(OSR - 1);

  logic            tick;
  logic            sync1;
  logic            sync2;
  uart_state_t     state;
  logic [OsW-1:0]  os_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  // Set on the stop-sample clk; the hand-off to rx_data happens one clk later.
  logic            accept;

  uart_baud_tick #(
    .DIV (Div)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser; only sync2 is ever sampled. Resets to idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      accept    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      accept    <= 1'b0;

      // Consumer hand-off. An ack arriving with the new byte frees the slot,
      // so the new byte replaces the old one without an overrun.
      if (accept) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end

      if (tick) begin
        unique case (state)
          StIdle: begin
            if (!sync2) begin
              state  <= StStart;
              os_cnt <= '0;
            end
          end
          StStart: begin
            if (os_cnt == HalfLast) begin
              if (!sync2) begin
                state   <= StData;
                os_cnt  <= '0;
                bit_idx <= '0;
              end else begin
                // Low pulse shorter than half a bit: treat as noise.
                state <= StIdle;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          StData: begin
            if (os_cnt == BitLast) begin
              os_cnt <= '0;
              shift  <= {sync2, shift[7:1]};
              if (bit_idx == 3'd7) begin
                state <= StStop;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          StStop: begin
            if (os_cnt == BitLast) begin
              os_cnt <= '0;
              if (sync2) begin
                accept <= 1'b1;
                state  <= StIdle;
              end else begin
                frame_err <= 1'b1;
                state     <= StWaitHigh;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          StWaitHigh: begin
            // A held-low line (break) must not look like a new start bit.
            if (sync2) begin
              state <= StIdle;
            end
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

  assign busy = (state != StIdle);

endmodule
